serial_borrow_subtractor: RTL and testbench

Bit-serial ripple-borrow subtractor: computes diff = a - b - bin, one bit per clock, LSB first, and reports the final borrow and a signed-overflow flag.
It is the inverse-direction companion of the team's combinational ripple carry adder. It trades WIDTH cycles of latency for a single 1-bit full-subtractor cell.
Operands arrive and results leave through valid/ready handshakes, so it drops into the same datapath test harnesses.

---
 rtl/serial_borrow_subtractor_pkg.sv | 15 +
 rtl/serial_borrow_subtractor_full_subtractor.sv | 16 +
 rtl/serial_borrow_subtractor.sv | 119 +++++++++++
 tb/tb_serial_borrow_subtractor.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_borrow_subtractor_pkg.sv
// Shared types and sizing helpers for the bit-serial borrow subtractor.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // The counter must be able to hold WIDTH itself (the finalisation step).
  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/serial_borrow_subtractor_full_subtractor.sv
// One-bit full subtractor: d = a - b - bin, bout set when the bit underflows.
module full_subtractor (
  input  logic i_a,
  input  logic i_b,
  input  logic i_bin,
  output logic o_d,
  output logic o_bout
);

  logic w_axb;

  assign w_axb  = i_a ^ i_b;
  assign o_d    = w_axb ^ i_bin;
  assign o_bout = (~i_a & i_b) | (~w_axb & i_bin);

endmodule

// File: rtl/serial_borrow_subtractor.sv
// Bit-serial ripple-borrow subtractor: diff = a - b - bin, one bit per clock, LSB first.
// Handshakes: a transfer happens on a rising edge where valid && ready; valid never depends on ready.
module serial_borrow_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             ovf,
  output logic             busy,
  output state_e           dbg_state
);

  localparam int CNT_W = cnt_w(WIDTH);

  state_e           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic             r_br;
  logic             r_a_msb;
  logic             r_b_msb;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_busy;
  logic [WIDTH-1:0] r_diff;
  logic             r_borrow;
  logic             r_ovf;
  logic             w_d;
  logic             w_bout;

  full_subtractor u_fs (
    .i_a    (r_a[0]),
    .i_b    (r_b[0]),
    .i_bin  (r_br),
    .o_d    (w_d),
    .o_bout (w_bout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_acc       <= '0;
      r_br        <= 1'b0;
      r_a_msb     <= 1'b0;
      r_b_msb     <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_diff      <= '0;
      r_borrow    <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a        <= a;
            r_b        <= b;
            r_br       <= bin;
            r_a_msb    <= a[WIDTH-1];
            r_b_msb    <= b[WIDTH-1];
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= RUN;
          end
        end
        RUN: begin
          // One extra RUN step after the last bit moves the accumulator to the outputs.
          if (r_cnt == CNT_W'(WIDTH)) begin
            r_diff      <= r_acc;
            r_borrow    <= r_br;
            r_ovf       <= (r_a_msb != r_b_msb) && (r_acc[WIDTH-1] != r_a_msb);
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_acc <= {w_d, r_acc[WIDTH-1:1]};
            r_a   <= r_a >> 1;
            r_b   <= r_b >> 1;
            r_br  <= w_bout;
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign diff      = r_diff;
  assign borrow    = r_borrow;
  assign ovf       = r_ovf;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_serial_borrow_subtractor.sv
// Bench for serial_borrow_subtractor: directed vectors, backpressure, mid-op reset, random back-to-back.
module tb_serial_borrow_subtractor;
  import serial_sub_pkg::*;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         borrow;
  logic         ovf;
  logic         busy;
  state_e       dbg_state;

  int pass_cnt  = 0;
  int check_cnt = 0;
  int cyc       = 0;
  logic mon_en  = 1'b0;
  logic [W+1:0] exp_q[$];

  serial_borrow_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .borrow    (borrow),
    .ovf       (ovf),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  // Plain integer arithmetic: wrap modulo 2^W, borrow is the lost sign bit.
  function automatic logic [W+1:0] model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                         input logic bv_in);
    int r;
    logic [W-1:0] d;
    logic br, ov;
    r  = int'(av) - int'(bv) - int'(bv_in);
    br = (r < 0);
    d  = W'(r + (1 << W));
    ov = (av[W-1] != bv[W-1]) && (d[W-1] != av[W-1]);
    return {ov, br, d};
  endfunction

  // ---------------- drivers ----------------
  task automatic do_accept(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bv_in,
                           output int ok);
    a = av; b = bv; bin = bv_in; in_valid = 1'b1; ok = 0;
    for (int k = 0; k < 60; k++) begin
      if (in_ready) begin
        tick();
        ok = 1;
        break;
      end
      tick();
    end
    in_valid = 1'b0;
    a = 'x;
    b = 'x;
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin
      tick();
      lat++;
    end
  endtask

  // ---------------- scoreboard monitor (back-to-back) ----------------
  always @(posedge clk) begin
    #1;
    if (mon_en && out_valid && out_ready) begin
      check_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL b2b_unexpected: got {ovf,borrow,diff}=%b, expected no result", {ovf, borrow, diff});
      end else begin
        logic [W+1:0] e;
        e = exp_q.pop_front();
        if ({ovf, borrow, diff} !== e)
          $display("FAIL b2b_result: got {ovf,borrow,diff}=%b expected %b", {ovf, borrow, diff}, e);
        else pass_cnt++;
      end
    end
  end

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; bin = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    check_cnt++;
    if ({in_ready, out_valid, busy, borrow, ovf} !== 5'b10000)
      $display("FAIL reset_flags: got {in_ready,out_valid,busy,borrow,ovf}=%b expected 10000",
               {in_ready, out_valid, busy, borrow, ovf});
    else pass_cnt++;
    check_cnt++;
    if (diff !== '0 || dbg_state !== IDLE)
      $display("FAIL reset_state: got diff=%b state=%0d expected 0000 state=0", diff, dbg_state);
    else pass_cnt++;
  endtask

  task automatic test_directed();
    logic [W-1:0] ta[5] = '{4'b0101, 4'b0011, 4'b0000, 4'b1000, 4'b0111};
    logic [W-1:0] tb[5] = '{4'b0011, 4'b0101, 4'b0001, 4'b0001, 4'b1111};
    logic         tc[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [W+1:0] te[5] = '{6'b00_0010, 6'b01_1110, 6'b01_1110, 6'b10_0111, 6'b01_0111};
    int ok, lat;
    for (int i = 0; i < 5; i++) begin
      do_accept(ta[i], tb[i], tc[i], ok);
      wait_result(lat);
      check_cnt++;
      if (ok != 1 || lat != W + 1)
        $display("FAIL dir%0d_latency: got accept=%0d latency=%0d expected accept=1 latency=%0d",
                 i, ok, lat, W + 1);
      else pass_cnt++;
      check_cnt++;
      if ({ovf, borrow, diff} !== te[i])
        $display("FAIL dir%0d_result: got {ovf,borrow,diff}=%b expected %b", i, {ovf, borrow, diff}, te[i]);
      else pass_cnt++;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check_cnt++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || diff !== te[i][W-1:0])
        $display("FAIL dir%0d_release: got out_valid=%b in_ready=%b diff=%b expected 0 1 %b",
                 i, out_valid, in_ready, diff, te[i][W-1:0]);
      else pass_cnt++;
    end
  endtask

  task automatic test_backpressure();
    logic [W+1:0] e;
    int ok, lat;
    e = model(4'b1100, 4'b0110, 1'b1);
    do_accept(4'b1100, 4'b0110, 1'b1, ok);
    wait_result(lat);
    for (int k = 0; k < 7; k++) begin
      if (k == 3) begin
        in_valid = 1'b1; a = 4'b0001; b = 4'b0001; bin = 1'b0;
      end
      tick();
      in_valid = 1'b0;
      check_cnt++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || {ovf, borrow, diff} !== e)
        $display("FAIL bp_hold%0d: got out_valid=%b in_ready=%b res=%b expected 1 0 %b",
                 k, out_valid, in_ready, {ovf, borrow, diff}, e);
      else pass_cnt++;
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tick();
    tick();
    check_cnt++;
    if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0 || diff !== e[W-1:0])
      $display("FAIL bp_not_queued: got busy=%b in_ready=%b out_valid=%b diff=%b expected 0 1 0 %b",
               busy, in_ready, out_valid, diff, e[W-1:0]);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int ok, lat;
    do_accept(4'b1010, 4'b0011, 1'b0, ok);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_cnt++;
    if (dbg_state !== IDLE || out_valid !== 1'b0 || diff !== '0 || in_ready !== 1'b1 || busy !== 1'b0)
      $display("FAIL midrst_state: got state=%0d out_valid=%b diff=%b in_ready=%b busy=%b expected 0 0 0000 1 0",
               dbg_state, out_valid, diff, in_ready, busy);
    else pass_cnt++;
    do_accept(4'b1111, 4'b1111, 1'b1, ok);
    wait_result(lat);
    check_cnt++;
    if (lat != W + 1 || diff !== 4'b1111 || borrow !== 1'b1 || ovf !== 1'b0)
      $display("FAIL midrst_newop: got latency=%0d diff=%b borrow=%b ovf=%b expected %0d 1111 1 0",
               lat, diff, borrow, ovf, W + 1);
    else pass_cnt++;
    out_ready = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back();
    int last_acc, guard;
    logic [W-1:0] av, bv;
    logic         cv;
    out_ready = 1'b1;
    mon_en    = 1'b1;
    last_acc  = -1;
    for (int n = 0; n < 20; n++) begin
      av = W'($urandom_range(0, (1 << W) - 1));
      bv = W'($urandom_range(0, (1 << W) - 1));
      cv = 1'($urandom_range(0, 1));
      a = av; b = bv; bin = cv; in_valid = 1'b1;
      guard = 0;
      while (!in_ready && guard < 50) begin
        tick();
        guard++;
      end
      tick();
      exp_q.push_back(model(av, bv, cv));
      if (last_acc >= 0) begin
        check_cnt++;
        if (guard >= 50 || cyc - last_acc != W + 3)
          $display("FAIL b2b_spacing%0d: got %0d cycles expected %0d", n, cyc - last_acc, W + 3);
        else pass_cnt++;
      end
      last_acc = cyc;
    end
    in_valid = 1'b0;
    guard = 0;
    while (exp_q.size() != 0 && guard < 100) begin
      tick();
      guard++;
    end
    tick();
    mon_en = 1'b0;
    check_cnt++;
    if (exp_q.size() != 0)
      $display("FAIL b2b_drain: got %0d results outstanding expected 0", exp_q.size());
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
